// File: rtl/udp_deadlock_monitor_gen_if.sv
// Bundle of monitor inputs (stall flags, enable, clear) and deadlock reports.
// The master side drives the flags; the slave side is the monitor.
interface udp_deadlock_monitor_gen_if #(
    parameter int NUM_PROC = 6,
    parameter int NUM_AXIS = 4,
    parameter int INFO_W   = 4,
    parameter int CNT_W    = 32
);
    localparam int IDX_W = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;

    logic                       enable;
    logic                       clear;
    logic [NUM_AXIS-1:0]        axis_block_sigs;
    logic [NUM_PROC-1:0]        proc_idle_sigs;
    logic [NUM_PROC-1:0]        proc_chan_block_sigs;
    logic                       block;
    logic                       block_event;
    logic [NUM_AXIS*INFO_W-1:0] axis_block_info;
    logic [IDX_W-1:0]           first_axis_idx;
    logic [CNT_W-1:0]           stall_count;

    modport master (
        output enable, clear, axis_block_sigs, proc_idle_sigs, proc_chan_block_sigs,
        input  block, block_event, axis_block_info, first_axis_idx, stall_count
    );

    modport slave (
        input  enable, clear, axis_block_sigs, proc_idle_sigs, proc_chan_block_sigs,
        output block, block_event, axis_block_info, first_axis_idx, stall_count
    );
endinterface

// File: rtl/udp_deadlock_monitor_gen.sv
// Dataflow deadlock monitor: declares a deadlock once every process is stopped
// and at least one is stuck on an AXIS channel for HOLD_CYCLES cycles in a row,
// then reports which channels were blocked and how long the block has lasted.
module udp_deadlock_monitor_gen #(
    parameter int                    NUM_PROC    = 6,
    parameter int                    NUM_AXIS    = 4,
    parameter int                    INFO_W      = 4,
    parameter logic [8*NUM_AXIS-1:0] AXIS_OWNER  = 32'h05040301,
    parameter int                    HOLD_CYCLES = 16,
    parameter int                    CNT_W       = 32,
    parameter bit                    STICKY      = 1'b1
) (
    input logic                       clock,
    input logic                       reset,
    udp_deadlock_monitor_gen_if.slave mon
);
    localparam int IDX_W  = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {S_RUN, S_PEND, S_BLOCK} state_e;

    state_e                     state_q, state_d;
    logic [HOLD_W-1:0]          hold_cnt_q, hold_cnt_d;
    logic                       block_event_q, block_event_d;
    logic [NUM_AXIS*INFO_W-1:0] info_q, info_d;
    logic [IDX_W-1:0]           first_idx_q, first_idx_d;
    logic [CNT_W-1:0]           stall_count_q, stall_count_d;

    logic [NUM_PROC-1:0]        proc_axis_block;
    logic [NUM_PROC-1:0]        proc_stop;
    logic                       stall_cond;
    logic [NUM_AXIS*INFO_W-1:0] info_sample;
    logic [IDX_W-1:0]           lowest_idx;

    // Fold channel blocks onto their owning processes and form the stall condition.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        proc_axis_block = '0;
        for (int p = 0; p < NUM_PROC; p++) begin
            for (int i = 0; i < NUM_AXIS; i++) begin
                // Owners outside 0..NUM_PROC-1 never match and are thereby ignored.
                if (AXIS_OWNER[8*i +: 8] == 8'(p)) begin
                    proc_axis_block[p] = proc_axis_block[p] | mon.axis_block_sigs[i];
                end
            end
        end
        proc_stop  = mon.proc_idle_sigs | mon.proc_chan_block_sigs | proc_axis_block;
        stall_cond = mon.enable & (|proc_axis_block) & (&proc_stop);
    end

    // Per-channel info codes and lowest blocked channel, sampled from the live flags.
    always_comb begin
        info_sample = '0;
        lowest_idx  = '0;
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (mon.axis_block_sigs[i]) begin
                info_sample[INFO_W*i +: INFO_W] = ~(INFO_W'(1) << (i % INFO_W));
                lowest_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic: stall must persist HOLD_CYCLES cycles; clear overrides all.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (mon.clear) begin
            state_d    = S_RUN;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stall_cond) begin
                        if (HOLD_CYCLES == 1) begin
                            state_d = S_BLOCK;
                        end else begin
                            state_d    = S_PEND;
                            hold_cnt_d = HOLD_W'(1);
                        end
                    end
                end
                S_PEND: begin
                    if (!stall_cond) begin
                        state_d    = S_RUN;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = S_BLOCK;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                S_BLOCK: begin
                    if (!STICKY && !stall_cond) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Report logic: capture on BLOCK entry, update while blocked, zero otherwise.
    always_comb begin
        block_event_d = 1'b0;
        info_d        = '0;
        first_idx_d   = '0;
        stall_count_d = '0;
        if (state_d == S_BLOCK) begin
            if (state_q != S_BLOCK) begin
                block_event_d = 1'b1;
                info_d        = info_sample;
                first_idx_d   = lowest_idx;
                stall_count_d = CNT_W'(1);
            end else begin
                info_d        = STICKY ? info_q : info_sample;
                first_idx_d   = first_idx_q;
                stall_count_d = (&stall_count_q) ? stall_count_q : stall_count_q + CNT_W'(1);
            end
        end
    end

    // State and report registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_RUN;
            hold_cnt_q    <= '0;
            block_event_q <= 1'b0;
            info_q        <= '0;
            first_idx_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            block_event_q <= block_event_d;
            info_q        <= info_d;
            first_idx_q   <= first_idx_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign mon.block           = (state_q == S_BLOCK);
    assign mon.block_event     = block_event_q;
    assign mon.axis_block_info = info_q;
    assign mon.first_axis_idx  = first_idx_q;
    assign mon.stall_count     = stall_count_q;
endmodule
